// File: rtl/mult_product_accumulator.sv
// Accumulates a run of unsigned multiplier products and returns the sum on a valid/ready handshake.
// Optional macro ACC_SATURATE_EN: clamp the sum at all ones on carry out instead of wrapping.
module mult_product_accumulator #(
  parameter int N     = 8,
  parameter int LEN_W = 8,
  parameter int ACC_W = 2*N + LEN_W
) (
  input  logic               clk,
  input  logic               Reset_n,
  input  logic               Start,
  input  logic [LEN_W-1:0]   Len_in,
  input  logic [2*N-1:0]     P_in,
  input  logic               P_valid,
  output logic [ACC_W-1:0]   Acc_out,
  output logic               Acc_valid,
  input  logic               Acc_ready,
  output logic               Busy,
  output logic               Overflow
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [LEN_W-1:0] count;
  logic [ACC_W-1:0] acc;
  logic             overflow;
  logic             load_run;
  logic             accept;
  logic [ACC_W:0]   sum;
  logic             carry;

  // One extra bit on the adder exposes the carry out of the accumulator
  assign sum   = {1'b0, acc} + (ACC_W+1)'(P_in);
  assign carry = sum[ACC_W];

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load_run   = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          load_run   = 1'b1;
          state_next = (Len_in == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (P_valid) begin
          accept = 1'b1;
          if (count == LEN_W'(1)) state_next = DONE;
        end
      end
      DONE: begin
        if (Acc_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      acc      <= '0;
      overflow <= 1'b0;
      count    <= '0;
    end else if (load_run) begin
      acc      <= '0;
      overflow <= 1'b0;
      count    <= Len_in;
    end else if (accept) begin
      count <= count - LEN_W'(1);
      if (carry) overflow <= 1'b1;
`ifdef ACC_SATURATE_EN
      // Once clamped, any later term carries again (or adds zero), so the value sticks at all ones
      acc <= carry ? '1 : sum[ACC_W-1:0];
`else
      acc <= sum[ACC_W-1:0];
`endif
    end
  end

  assign Acc_out   = acc;
  assign Acc_valid = (state == DONE);
  assign Busy      = (state != IDLE);
  assign Overflow  = overflow;

endmodule

// File: tb/tb_mult_product_accumulator.sv
// Randomized self-checking bench: a default-width instance and a 16-bit accumulator instance share stimulus
// and are compared against a run-total model that wraps or saturates according to ACC_SATURATE_EN.
module tb_mult_product_accumulator;
  localparam int N       = 8;
  localparam int LEN_W   = 8;
  localparam int ACC_W   = 2*N + LEN_W;
  localparam int SMALL_W = 16;

  logic             clk = 1'b0;
  logic             Reset_n = 1'b1;
  logic             Start = 1'b0;
  logic             P_valid = 1'b0;
  logic             Acc_ready = 1'b0;
  logic [LEN_W-1:0] Len_in = '0;
  logic [2*N-1:0]   P_in = '0;

  logic [ACC_W-1:0]   acc_a;
  logic               valid_a, busy_a, ovf_a;
  logic [SMALL_W-1:0] acc_b;
  logic               valid_b, busy_b, ovf_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mult_product_accumulator #(.N(N), .LEN_W(LEN_W)) dut_a (
    .clk(clk), .Reset_n(Reset_n), .Start(Start), .Len_in(Len_in), .P_in(P_in), .P_valid(P_valid),
    .Acc_out(acc_a), .Acc_valid(valid_a), .Acc_ready(Acc_ready), .Busy(busy_a), .Overflow(ovf_a));

  mult_product_accumulator #(.N(N), .LEN_W(LEN_W), .ACC_W(SMALL_W)) dut_b (
    .clk(clk), .Reset_n(Reset_n), .Start(Start), .Len_in(Len_in), .P_in(P_in), .P_valid(P_valid),
    .Acc_out(acc_b), .Acc_valid(valid_b), .Acc_ready(Acc_ready), .Busy(busy_b), .Overflow(ovf_b));

  // Reported sum for a run whose true total is 'total', in an accumulator of width w
  function automatic longint model_acc(longint total, int w);
    longint maxv = (longint'(1) << w) - 1;
    if (total <= maxv) return total;
`ifdef ACC_SATURATE_EN
    return maxv;
`else
    return total & maxv;
`endif
  endfunction

  function automatic logic [ACC_W+2:0] model_a(longint total, bit v, bit b);
    return {v, b, total > ((longint'(1) << ACC_W) - 1), ACC_W'(model_acc(total, ACC_W))};
  endfunction

  function automatic logic [SMALL_W+2:0] model_b(longint total, bit v, bit b);
    return {v, b, total > ((longint'(1) << SMALL_W) - 1), SMALL_W'(model_acc(total, SMALL_W))};
  endfunction

  function automatic logic [2*N-1:0] rand_product();
    return (2*N)'($urandom_range(255) * $urandom_range(255));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts a run, feeds its terms with idle gaps, and leaves the DUTs waiting in DONE
  task automatic run_terms(input string name, input int len, input logic [2*N-1:0] prods[$],
                           input int gaps[$], output longint total);
    Start = 1'b1; Len_in = LEN_W'(len); P_valid = 1'b1; P_in = 16'hFFFF;
    step();
    Start = 1'b0; P_valid = 1'b0;
    total = 0;
    checks++;
    if ({valid_a, busy_a, ovf_a, acc_a} !== model_a(0, len == 0, 1'b1)) begin
      errors++; $display("[TB] FAIL %s start_a: got %h expected %h", name, {valid_a, busy_a, ovf_a, acc_a}, model_a(0, len == 0, 1'b1));
    end
    for (int i = 0; i < len; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        P_in = rand_product(); Acc_ready = 1'($urandom_range(1)); Start = 1'($urandom_range(1));
        step();
        checks++;
        if ({valid_a, busy_a, ovf_a, acc_a} !== model_a(total, 1'b0, 1'b1)) begin
          errors++; $display("[TB] FAIL %s gap_a: got %h expected %h", name, {valid_a, busy_a, ovf_a, acc_a}, model_a(total, 1'b0, 1'b1));
        end
      end
      Acc_ready = 1'b0; Start = 1'b0; P_valid = 1'b1; P_in = prods[i];
      step();
      P_valid = 1'b0;
      total += longint'(prods[i]);
      checks++;
      if ({valid_a, busy_a, ovf_a, acc_a} !== model_a(total, i == len - 1, 1'b1)) begin
        errors++; $display("[TB] FAIL %s term%0d_a: got %h expected %h", name, i, {valid_a, busy_a, ovf_a, acc_a}, model_a(total, i == len - 1, 1'b1));
      end
      checks++;
      if ({valid_b, busy_b, ovf_b, acc_b} !== model_b(total, i == len - 1, 1'b1)) begin
        errors++; $display("[TB] FAIL %s term%0d_b: got %h expected %h", name, i, {valid_b, busy_b, ovf_b, acc_b}, model_b(total, i == len - 1, 1'b1));
      end
    end
  endtask

  task automatic handshake(input string name, input longint total);
    Acc_ready = 1'b1; Start = 1'b0;
    step();
    Acc_ready = 1'b0;
    checks++;
    if ({valid_a, busy_a, ovf_a, acc_a} !== model_a(total, 1'b0, 1'b0)) begin
      errors++; $display("[TB] FAIL %s handshake_a: got %h expected %h", name, {valid_a, busy_a, ovf_a, acc_a}, model_a(total, 1'b0, 1'b0));
    end
    checks++;
    if ({valid_b, busy_b, ovf_b, acc_b} !== model_b(total, 1'b0, 1'b0)) begin
      errors++; $display("[TB] FAIL %s handshake_b: got %h expected %h", name, {valid_b, busy_b, ovf_b, acc_b}, model_b(total, 1'b0, 1'b0));
    end
  endtask

  task automatic test_reset();
    #1 Reset_n = 1'b0;
    #1;
    checks++;
    if ({valid_a, busy_a, ovf_a, acc_a} !== '0) begin
      errors++; $display("[TB] FAIL reset_a: got %h expected 0", {valid_a, busy_a, ovf_a, acc_a});
    end
    step(); step();
    Reset_n = 1'b1;
    step();
    checks++;
    if ({valid_b, busy_b, ovf_b, acc_b} !== '0) begin
      errors++; $display("[TB] FAIL reset_b: got %h expected 0", {valid_b, busy_b, ovf_b, acc_b});
    end
  endtask

  task automatic test_basic();
    logic [2*N-1:0] q[$];
    int g[$];
    longint total;
    q = {16'h0006, 16'h000C, 16'h0023};
    g = {0, 0, 0};
    run_terms("basic", 3, q, g, total);
    checks++;
    if (acc_a !== 24'h35 || ovf_a !== 1'b0) begin
      errors++; $display("[TB] FAIL basic_sum: got %h ovf %b expected 35 ovf 0", acc_a, ovf_a);
    end
    handshake("basic", total);
  endtask

  task automatic test_gaps();
    logic [2*N-1:0] q[$];
    int g[$];
    longint total;
    q = {16'hFE01, 16'hFE01, 16'hFE01, 16'hFE01};
    g = {0, 1, 2, 0};
    run_terms("gaps", 4, q, g, total);
    checks++;
    if (acc_a !== 24'h3F804 || valid_a !== 1'b1) begin
      errors++; $display("[TB] FAIL gaps_sum: got %h valid %b expected 3f804 valid 1", acc_a, valid_a);
    end
    handshake("gaps", total);
  endtask

  task automatic test_overflow();
    logic [2*N-1:0] q[$];
    int g[$];
    longint total;
    logic [SMALL_W-1:0] exp_b;
`ifdef ACC_SATURATE_EN
    exp_b = 16'hFFFF;
`else
    exp_b = 16'hFC02;
`endif
    q = {16'hFE01, 16'hFE01};
    g = {0, 0};
    run_terms("overflow", 2, q, g, total);
    checks++;
    if (acc_b !== exp_b || ovf_b !== 1'b1) begin
      errors++; $display("[TB] FAIL overflow_small: got %h ovf %b expected %h ovf 1", acc_b, ovf_b, exp_b);
    end
    checks++;
    if (acc_a !== 24'h1FC02 || ovf_a !== 1'b0) begin
      errors++; $display("[TB] FAIL overflow_wide: got %h ovf %b expected 1fc02 ovf 0", acc_a, ovf_a);
    end
    handshake("overflow", total);
  endtask

  task automatic test_zero_len();
    logic [2*N-1:0] q[$];
    int g[$];
    longint total;
    run_terms("zero_len", 0, q, g, total);
    for (int i = 0; i < 5; i++) begin
      Start = 1'(i % 2 == 0); Len_in = 8'd3; P_valid = 1'b1; P_in = rand_product(); Acc_ready = 1'b0;
      step();
      checks++;
      if ({valid_a, busy_a, ovf_a, acc_a} !== model_a(0, 1'b1, 1'b1)) begin
        errors++; $display("[TB] FAIL zero_len_hold%0d: got %h expected %h", i, {valid_a, busy_a, ovf_a, acc_a}, model_a(0, 1'b1, 1'b1));
      end
    end
    P_valid = 1'b0;
    handshake("zero_len", total);
  endtask

  task automatic test_reset_midrun();
    logic [2*N-1:0] q[$];
    int g[$];
    longint total;
    Start = 1'b1; Len_in = 8'd5;
    step();
    Start = 1'b0; P_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      P_in = rand_product() | 16'h0001;
      step();
    end
    P_valid = 1'b0;
    #2 Reset_n = 1'b0;
    #1;
    checks++;
    if ({valid_a, busy_a, ovf_a, acc_a} !== '0 || {valid_b, busy_b, ovf_b, acc_b} !== '0) begin
      errors++; $display("[TB] FAIL midrun_reset: got %h / %h expected 0", {valid_a, busy_a, ovf_a, acc_a}, {valid_b, busy_b, ovf_b, acc_b});
    end
    step();
    Reset_n = 1'b1;
    step();
    q = {16'h0009};
    g = {0};
    run_terms("after_reset", 1, q, g, total);
    checks++;
    if (acc_a !== 24'h9 || ovf_a !== 1'b0) begin
      errors++; $display("[TB] FAIL after_reset_sum: got %h ovf %b expected 9 ovf 0", acc_a, ovf_a);
    end
    handshake("after_reset", total);
  endtask

  task automatic test_back_to_back();
    logic [2*N-1:0] q[$];
    int g[$];
    longint total;
    q = {16'hFE01, 16'h1234};
    g = {0, 0};
    run_terms("b2b_first", 2, q, g, total);
    Acc_ready = 1'b1; Start = 1'b1; Len_in = 8'd2;
    step();
    Acc_ready = 1'b0;
    checks++;
    if ({valid_a, busy_a, ovf_a, acc_a} !== model_a(total, 1'b0, 1'b0)) begin
      errors++; $display("[TB] FAIL b2b_ignore_start: got %h expected %h", {valid_a, busy_a, ovf_a, acc_a}, model_a(total, 1'b0, 1'b0));
    end
    step();
    Start = 1'b0;
    checks++;
    if ({valid_b, busy_b, ovf_b, acc_b} !== model_b(0, 1'b0, 1'b1)) begin
      errors++; $display("[TB] FAIL b2b_new_run: got %h expected %h", {valid_b, busy_b, ovf_b, acc_b}, model_b(0, 1'b0, 1'b1));
    end
    total = 0;
    for (int i = 0; i < 2; i++) begin
      P_valid = 1'b1; P_in = rand_product();
      total += longint'(P_in);
      step();
    end
    P_valid = 1'b0;
    checks++;
    if ({valid_a, busy_a, ovf_a, acc_a} !== model_a(total, 1'b1, 1'b1)) begin
      errors++; $display("[TB] FAIL b2b_second_sum: got %h expected %h", {valid_a, busy_a, ovf_a, acc_a}, model_a(total, 1'b1, 1'b1));
    end
    handshake("b2b_second", total);
  endtask

  task automatic test_random();
    logic [2*N-1:0] q[$];
    int g[$];
    longint total;
    int len;
    for (int r = 0; r < 25; r++) begin
      q.delete(); g.delete();
      len = $urandom_range(8);
      for (int i = 0; i < len; i++) begin
        q.push_back(rand_product());
        g.push_back($urandom_range(2));
      end
      run_terms("random", len, q, g, total);
      for (int w = 0; w < int'($urandom_range(2)); w++) step();
      handshake("random", total);
      for (int w = 0; w < int'($urandom_range(1)); w++) step();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_overflow();
    test_zero_len();
    test_reset_midrun();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
